// File: rtl/ip_msx_cart_bridge_if.sv
// MSX cartridge bus pins and VDP request/acknowledge handshake seen by the bridge.
interface ip_msx_cart_bridge_if;
  logic       n_ce;
  logic       n_trd;
  logic       n_twr;
  logic [1:0] ta;
  logic [7:0] td_in;
  logic [7:0] td_out;
  logic       tdir;
  logic       twait;
  logic       vdp_req;
  logic       vdp_ack;
  logic       vdp_wrt;
  logic [1:0] vdp_adr;
  logic [7:0] vdp_wdata;
  logic [7:0] vdp_rdata;
  logic       timeout_err;

  modport slave (
    input  n_ce, n_trd, n_twr, ta, td_in, vdp_ack, vdp_rdata,
    output td_out, tdir, twait, vdp_req, vdp_wrt, vdp_adr, vdp_wdata, timeout_err
  );

  modport master (
    output n_ce, n_trd, n_twr, ta, td_in, vdp_ack, vdp_rdata,
    input  td_out, tdir, twait, vdp_req, vdp_wrt, vdp_adr, vdp_wdata, timeout_err
  );
endinterface

// File: rtl/ip_msx_cart_bridge.sv
// Bridges asynchronous MSX cartridge bus cycles onto a VDP request/ack handshake,
// holding the MSX in wait until the VDP answers or a timeout forces release.
module ip_msx_cart_bridge #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 reset,
  ip_msx_cart_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] ce_sync_q, ce_sync_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0] live_q, live_d;
  logic                   prev_act_q, prev_act_d;
  logic                   s_ce, s_rd, s_wr, sync_ok;
  logic                   rd_act, wr_act, bus_act, start, timeout_hit;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req_q, req_d;
  logic       tdir_q, tdir_d;
  logic       terr_q, terr_d;
  logic       wrt_q, wrt_d;
  logic       drop_q, drop_d;
  logic [1:0] adr_q, adr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] td_out_q, td_out_d;

  // live_q marks when the chains carry real pin samples rather than reset fill
  always_comb begin
    ce_sync_d = {ce_sync_q[SYNC_STAGES-2:0], bus.n_ce};
    rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], bus.n_trd};
    wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], bus.n_twr};
    live_d    = {live_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign s_ce    = ce_sync_q[SYNC_STAGES-1];
  assign s_rd    = rd_sync_q[SYNC_STAGES-1];
  assign s_wr    = wr_sync_q[SYNC_STAGES-1];
  assign sync_ok = live_q[SYNC_STAGES-1];

  assign rd_act      = ~s_ce & ~s_rd &  s_wr;
  assign wr_act      = ~s_ce & ~s_wr &  s_rd;
  assign bus_act     = rd_act | wr_act;
  // Until the chains are flushed, pretend the bus was active so an access held
  // across reset cannot produce a start edge.
  assign prev_act_d  = sync_ok ? bus_act : 1'b1;
  assign start       = bus_act & ~prev_act_q;
  assign timeout_hit = (cnt_q >= TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_sync_q  <= '1;
      rd_sync_q  <= '1;
      wr_sync_q  <= '1;
      live_q     <= '0;
      prev_act_q <= 1'b1;
    end else begin
      ce_sync_q  <= ce_sync_d;
      rd_sync_q  <= rd_sync_d;
      wr_sync_q  <= wr_sync_d;
      live_q     <= live_d;
      prev_act_q <= prev_act_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (bus.vdp_ack || timeout_hit) state_d = HOLD;
      HOLD:    if (!bus_act) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    wrt_d    = wrt_q;
    td_out_d = td_out_q;
    drop_d   = drop_q;
    terr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          adr_d  = bus.ta;
          wrt_d  = wr_act;
          cnt_d  = '0;
          drop_d = 1'b0;
          if (wr_act) wdata_d = bus.td_in;
        end
      end
      REQ: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        drop_d = drop_q | ~bus_act;
        if (bus.vdp_ack) begin
          if (!wrt_q) td_out_d = bus.vdp_rdata;
        end else if (timeout_hit) begin
          if (!wrt_q) td_out_d = 8'hFF;
          terr_d = 1'b1;
        end
      end
      default: ;
    endcase
    req_d  = (state_d == REQ);
    // A read abandoned during REQ must never turn the data bus around.
    tdir_d = (state_d == HOLD) & ~wrt_q & rd_act & ~drop_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      req_q    <= 1'b0;
      tdir_q   <= 1'b0;
      terr_q   <= 1'b0;
      wrt_q    <= 1'b0;
      drop_q   <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      td_out_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      tdir_q   <= tdir_d;
      terr_q   <= terr_d;
      wrt_q    <= wrt_d;
      drop_q   <= drop_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      td_out_q <= td_out_d;
    end
  end

  assign bus.td_out      = td_out_q;
  assign bus.tdir        = tdir_q;
  assign bus.twait       = req_q;
  assign bus.vdp_req     = req_q;
  assign bus.vdp_wrt     = wrt_q;
  assign bus.vdp_adr     = adr_q;
  assign bus.vdp_wdata   = wdata_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_ip_msx_cart_bridge.sv
// Directed bench for ip_msx_cart_bridge: a cycle-level bus model predicts every
// output each cycle, and literal expectations pin the key scenarios.
module tb_ip_msx_cart_bridge;
  localparam int SYNC = 2;
  localparam int TMO  = 255;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ip_msx_cart_bridge_if bif ();

  ip_msx_cart_bridge #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // VDP responder: acks on the ack_delay-th cycle that vdp_req is seen high.
  int ack_delay  = 0;
  int req_cycles = 0;
  always @(negedge clk) begin
    if (bif.vdp_req === 1'b1 && ack_delay > 0) begin
      req_cycles++;
      bif.vdp_ack = (req_cycles == ack_delay);
    end else begin
      req_cycles  = 0;
      bif.vdp_ack = 1'b0;
    end
  end

  int terr_cnt   = 0;
  int req_hi_cnt = 0;
  bit tdir_seen  = 0;
  always @(negedge clk) begin
    if (bif.timeout_err === 1'b1) terr_cnt++;
    if (bif.vdp_req === 1'b1) req_hi_cnt++;
    if (bif.tdir === 1'b1) tdir_seen = 1;
  end

  // Behavioural model: pins seen SYNC edges late, phases 0=idle 1=waiting 2=held.
  logic [2:0] hist[$];
  int   m_since = 0, m_ph = 0, m_cnt = 0;
  bit   m_prev_idle = 0, m_drop = 0, m_live = 0;
  logic e_req = 0, e_tdir = 0, e_terr = 0, e_wrt = 0;
  logic [1:0] e_adr = 0;
  logic [7:0] e_wdata = 0, e_tdout = 0;

  always @(posedge clk) begin
    logic [2:0] sv;
    bit s_rd, s_wr, act, start, valid;
    hist.push_front({bif.n_ce, bif.n_trd, bif.n_twr});
    if (hist.size() > 8) void'(hist.pop_back());
    if (reset) begin
      m_live = 1; m_since = 0; m_prev_idle = 0; m_ph = 0; m_cnt = 0; m_drop = 0;
      e_req = 0; e_tdir = 0; e_terr = 0; e_wrt = 0; e_adr = 0; e_wdata = 0; e_tdout = 0;
    end else begin
      m_since++;
      valid = (m_since >= SYNC + 1);
      sv    = valid ? hist[SYNC] : 3'b111;
      s_rd  = (sv == 3'b001);
      s_wr  = (sv == 3'b010);
      act   = s_rd || s_wr;
      start = act && m_prev_idle;
      m_prev_idle = valid && !act;
      e_terr = 0;
      if (m_ph == 0) begin
        if (start) begin
          m_ph = 1; e_adr = bif.ta; e_wrt = s_wr; m_cnt = 0; m_drop = 0;
          if (s_wr) e_wdata = bif.td_in;
        end
      end else if (m_ph == 1) begin
        if (!act) m_drop = 1;
        m_cnt++;
        if (bif.vdp_ack === 1'b1) begin
          if (!e_wrt) e_tdout = bif.vdp_rdata;
          m_ph = 2;
        end else if (m_cnt >= TMO) begin
          if (!e_wrt) e_tdout = 8'hFF;
          e_terr = 1; m_ph = 2;
        end
      end else if (!act) begin
        m_ph = 0;
      end
      e_req  = (m_ph == 1);
      e_tdir = (m_ph == 2) && !e_wrt && !m_drop && s_rd;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("req",       32'(bif.vdp_req),     32'(e_req));
      check("twait",     32'(bif.twait),       32'(e_req));
      check("tdir",      32'(bif.tdir),        32'(e_tdir));
      check("terr",      32'(bif.timeout_err), 32'(e_terr));
      check("vdp_wrt",   32'(bif.vdp_wrt),     32'(e_wrt));
      check("vdp_adr",   32'(bif.vdp_adr),     32'(e_adr));
      check("vdp_wdata", 32'(bif.vdp_wdata),   32'(e_wdata));
      check("td_out",    32'(bif.td_out),      32'(e_tdout));
    end
  end

  task automatic wait_hi(input string nm, input bit use_tdir, input int bound);
    int i = 0;
    while (((use_tdir ? bif.tdir : bif.vdp_req) !== 1'b1) && i < bound) begin
      @(negedge clk);
      i++;
    end
    check(nm, 32'(use_tdir ? bif.tdir : bif.vdp_req), 1);
  endtask

  task automatic count_req(input string nm, input int bound, output int n);
    n = 0;
    while (bif.vdp_req === 1'b1 && n < bound) begin
      n++;
      @(negedge clk);
    end
    check({nm, "_fell"}, 32'(bif.vdp_req), 0);
  endtask

  task automatic release_bus();
    bif.n_ce = 1'b1; bif.n_trd = 1'b1; bif.n_twr = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int snap;
    bif.n_ce = 1'b1; bif.n_trd = 1'b1; bif.n_twr = 1'b1;
    bif.ta = 2'b00; bif.td_in = 8'h00; bif.vdp_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_req",    32'(bif.vdp_req), 0);
    check("rst_td_out", 32'(bif.td_out),  0);
    check("rst_adr",    32'(bif.vdp_adr), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Write: req visible after edge SYNC+1, ack on 4th req cycle.
    ack_delay = 4;
    bif.n_ce = 1'b0; bif.n_twr = 1'b0; bif.ta = 2'b01; bif.td_in = 8'hA5;
    repeat (2) @(negedge clk);
    check("wr_req_edge2", 32'(bif.vdp_req), 0);
    @(negedge clk);
    check("wr_req_edge3", 32'(bif.vdp_req),   1);
    check("wr_twait",     32'(bif.twait),     1);
    check("wr_wrt",       32'(bif.vdp_wrt),   1);
    check("wr_adr",       32'(bif.vdp_adr),   1);
    check("wr_wdata",     32'(bif.vdp_wdata), 32'hA5);
    count_req("wr", 20, n);
    check("wr_req_len", 32'(n), 4);
    check("wr_tdir",    32'(bif.tdir), 0);
    bif.td_in = 8'h00;
    release_bus();
    check("wr_wdata_kept", 32'(bif.vdp_wdata), 32'hA5);

    // Read with data returned on ack.
    ack_delay = 2; bif.vdp_rdata = 8'h3C; bif.ta = 2'b00;
    bif.n_ce = 1'b0; bif.n_trd = 1'b0;
    wait_hi("rd_tdir_on", 1'b1, 20);
    check("rd_td_out", 32'(bif.td_out),  32'h3C);
    check("rd_wrt",    32'(bif.vdp_wrt), 0);
    check("rd_adr",    32'(bif.vdp_adr), 0);
    repeat (3) @(negedge clk);
    check("rd_tdir_held", 32'(bif.tdir), 1);
    bif.n_trd = 1'b1; bif.n_ce = 1'b1;
    n = 0;
    while (bif.tdir === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rd_tdir_off_delay", 32'(n), 32'(SYNC + 1));
    release_bus();

    // Read with no ack: forced release after TMO request cycles.
    ack_delay = 0; bif.vdp_rdata = 8'h77; bif.ta = 2'b10;
    snap = terr_cnt;
    bif.n_ce = 1'b0; bif.n_trd = 1'b0;
    wait_hi("to_req_rise", 1'b0, 20);
    count_req("to", 400, n);
    check("to_req_len", 32'(n), 32'(TMO));
    check("to_terr",    32'(bif.timeout_err), 1);
    check("to_td_out",  32'(bif.td_out),      32'hFF);
    check("to_twait",   32'(bif.twait),       0);
    check("to_tdir",    32'(bif.tdir),        1);
    @(negedge clk);
    check("to_terr_drop", 32'(bif.timeout_err), 0);
    release_bus();
    check("to_terr_once", 32'(terr_cnt - snap), 1);

    // Both strobes low is not an access.
    snap = req_hi_cnt;
    bif.n_ce = 1'b0; bif.n_trd = 1'b0; bif.n_twr = 1'b0;
    repeat (10) @(negedge clk);
    check("both_no_req", 32'(req_hi_cnt - snap), 0);
    check("both_twait",  32'(bif.twait), 0);
    release_bus();

    // Reset mid-REQ with the read held at the pins.
    ack_delay = 0; bif.ta = 2'b11;
    bif.n_ce = 1'b0; bif.n_trd = 1'b0;
    wait_hi("rr_req_rise", 1'b0, 20);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rr_req_off", 32'(bif.vdp_req), 0);
    snap = req_hi_cnt;
    repeat (12) @(negedge clk);
    check("rr_no_restart", 32'(req_hi_cnt - snap), 0);
    bif.n_trd = 1'b1;
    repeat (4) @(negedge clk);
    ack_delay = 2; bif.vdp_rdata = 8'h5A;
    bif.n_trd = 1'b0;
    wait_hi("rr_restart", 1'b0, 20);
    wait_hi("rr_tdir", 1'b1, 20);
    check("rr_td_out", 32'(bif.td_out), 32'h5A);
    release_bus();

    // Write strobe released two cycles into REQ; handshake still completes.
    ack_delay = 8; bif.ta = 2'b10; bif.td_in = 8'h3E;
    tdir_seen = 0;
    bif.n_ce = 1'b0; bif.n_twr = 1'b0;
    wait_hi("late_req_rise", 1'b0, 20);
    repeat (2) @(negedge clk);
    bif.n_twr = 1'b1; bif.n_ce = 1'b1;
    count_req("late", 20, n);
    check("late_req_len", 32'(n + 2), 8);
    check("late_wdata",   32'(bif.vdp_wdata), 32'h3E);
    repeat (6) @(negedge clk);
    check("late_tdir_never", 32'(tdir_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
